// File: rtl/piece_spawner.sv
// 7-bag piece spawner: LFSR-driven bag draw, one-piece preview,
// and spawn-row generation behind a ready/valid style handshake.
module piece_spawner #(
    parameter int          WIDTH     = 10,
    parameter int          SPAWN_COL = 4,
    parameter int          MODE      = 1,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           spawn_req,
    output logic           spawn_rdy,
    output logic           spawn_valid,
    output logic [2:0]     piece,
    output logic [2:0]     next_piece,
    output logic [1:WIDTH] line1,
    output logic [1:WIDTH] line2,
    output logic [2:0]     bag_left
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SPAWN,
        S_REFILL
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [6:0]     unused_q, unused_d;
    logic [2:0]     bag_q, bag_d;
    logic [2:0]     piece_q, piece_d;
    logic [2:0]     next_q, next_d;
    logic [1:WIDTH] line1_q, line1_d;
    logic [1:WIDTH] line2_q, line2_d;

    logic [7:0]     rem;
    logic [2:0]     idx;
    logic [2:0]     draw_code;
    logic [6:0]     draw_oh;
    logic [2:0]     cnt;
    logic           found;
    logic [6:0]     draw_mask;
    logic [2:0]     draw_left;
    logic [1:WIDTH] pat1, pat2;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // bit i of unused_q stands for code i+1; pick the idx-th set bit
    always_comb begin
        rem       = 8'd0;
        idx       = 3'd0;
        draw_code = 3'd0;
        draw_oh   = 7'd0;
        cnt       = 3'd0;
        found     = 1'b0;
        if (MODE != 0 && bag_q != 3'd0) begin
            rem = lfsr_q[7:0] % {5'd0, bag_q};
            idx = rem[2:0];
        end
        for (int i = 0; i < 7; i++) begin
            if (unused_q[i] && !found) begin
                if (cnt == idx) begin
                    draw_code = 3'(i + 1);
                    draw_oh   = 7'd1 << i;
                    found     = 1'b1;
                end
                cnt = cnt + 3'd1;
            end
        end
        if (bag_q == 3'd1) begin
            draw_mask = 7'h7F;
            draw_left = 3'd7;
        end else begin
            draw_mask = unused_q & ~draw_oh;
            draw_left = bag_q - 3'd1;
        end
    end

    always_comb begin
        pat1 = '0;
        pat2 = '0;
        unique case (next_q)
            3'd1: begin
                pat2[SPAWN_COL+1] = 1'b1;
                pat2[SPAWN_COL+2] = 1'b1;
                pat1[SPAWN_COL+1] = 1'b1;
                pat1[SPAWN_COL+2] = 1'b1;
            end
            3'd2: begin
                pat2[SPAWN_COL+1] = 1'b1;
                pat1[SPAWN_COL]   = 1'b1;
                pat1[SPAWN_COL+1] = 1'b1;
                pat1[SPAWN_COL+2] = 1'b1;
            end
            3'd3: begin
                pat2[SPAWN_COL]   = 1'b1;
                pat2[SPAWN_COL+1] = 1'b1;
                pat1[SPAWN_COL+1] = 1'b1;
                pat1[SPAWN_COL+2] = 1'b1;
            end
            3'd4: begin
                pat2[SPAWN_COL+1] = 1'b1;
                pat2[SPAWN_COL+2] = 1'b1;
                pat1[SPAWN_COL]   = 1'b1;
                pat1[SPAWN_COL+1] = 1'b1;
            end
            3'd5: begin
                pat2[SPAWN_COL]   = 1'b1;
                pat2[SPAWN_COL+1] = 1'b1;
                pat2[SPAWN_COL+2] = 1'b1;
                pat1[SPAWN_COL+2] = 1'b1;
            end
            3'd6: begin
                pat2[SPAWN_COL]   = 1'b1;
                pat2[SPAWN_COL+1] = 1'b1;
                pat2[SPAWN_COL+2] = 1'b1;
                pat1[SPAWN_COL]   = 1'b1;
            end
            3'd7: begin
                pat2[SPAWN_COL]   = 1'b1;
                pat2[SPAWN_COL+1] = 1'b1;
                pat2[SPAWN_COL+2] = 1'b1;
                pat2[SPAWN_COL+3] = 1'b1;
            end
            default: begin
                pat1 = '0;
                pat2 = '0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        unused_d = unused_q;
        bag_d    = bag_q;
        piece_d  = piece_q;
        next_d   = next_q;
        line1_d  = line1_q;
        line2_d  = line2_q;
        if (clear) begin
            state_d  = S_INIT;
            unused_d = 7'h7F;
            bag_d    = 3'd7;
            piece_d  = 3'd0;
            line1_d  = '0;
            line2_d  = '0;
        end else begin
            unique case (state_q)
                S_INIT, S_REFILL: begin
                    next_d   = draw_code;
                    unused_d = draw_mask;
                    bag_d    = draw_left;
                    state_d  = S_IDLE;
                end
                S_IDLE: begin
                    if (spawn_req) begin
                        piece_d = next_q;
                        line1_d = pat1;
                        line2_d = pat2;
                        state_d = S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    state_d = S_REFILL;
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            lfsr_q   <= SEED_EFF;
            unused_q <= 7'h7F;
            bag_q    <= 3'd7;
            piece_q  <= 3'd0;
            next_q   <= 3'd0;
            line1_q  <= '0;
            line2_q  <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            unused_q <= unused_d;
            bag_q    <= bag_d;
            piece_q  <= piece_d;
            next_q   <= next_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
        end
    end

    assign spawn_rdy   = (state_q == S_IDLE);
    assign spawn_valid = (state_q == S_SPAWN);
    assign piece       = piece_q;
    assign next_piece  = next_q;
    assign line1       = line1_q;
    assign line2       = line2_q;
    assign bag_left    = bag_q;

endmodule

// File: tb/tb_piece_spawner.sv
// Directed bench for piece_spawner: vector table plus hand sequences
// for back-to-back spawns, mid-SPAWN reset and random bag draws.
module tb_piece_spawner;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic req;
    logic req_r;

    logic        rdy, vld;
    logic [2:0]  pc, nx, bl;
    logic [1:10] l1, l2;

    logic        rdy16, vld16;
    logic [2:0]  pc16, nx16, bl16;
    logic [1:16] w1, w2;

    logic        rdyr, vldr;
    logic [2:0]  pcr, nxr, blr;
    logic [1:10] r1, r2;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    piece_spawner #(.WIDTH(10), .SPAWN_COL(4), .MODE(0)) u10 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .spawn_req(req),
        .spawn_rdy(rdy), .spawn_valid(vld), .piece(pc),
        .next_piece(nx), .line1(l1), .line2(l2), .bag_left(bl)
    );

    piece_spawner #(.WIDTH(16), .SPAWN_COL(12), .MODE(0)) u16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .spawn_req(req),
        .spawn_rdy(rdy16), .spawn_valid(vld16), .piece(pc16),
        .next_piece(nx16), .line1(w1), .line2(w2), .bag_left(bl16)
    );

    piece_spawner #(.WIDTH(10), .SPAWN_COL(4), .MODE(1)) urnd (
        .clk(clk), .rst_n(rst_n), .clear(clear), .spawn_req(req_r),
        .spawn_rdy(rdyr), .spawn_valid(vldr), .piece(pcr),
        .next_piece(nxr), .line1(r1), .line2(r2), .bag_left(blr)
    );

    typedef struct {
        logic        req;
        logic        clr;
        logic        valid;
        logic        rdy;
        logic [2:0]  piece;
        logic [2:0]  nxt;
        logic [2:0]  bag;
        logic [1:10] l1;
        logic [1:10] l2;
        logic [1:16] w1;
        logic [1:16] w2;
    } vec_t;

    vec_t vec [12];
    logic [2:0] got [70];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:10] O10 = 10'b0000110000;
    localparam logic [1:16] O16 = 16'b0000000000001100;
    localparam logic [1:10] T1 = 10'b0001110000;
    localparam logic [1:10] T2 = 10'b0000100000;
    localparam logic [1:16] T16A = 16'b0000000000011100;
    localparam logic [1:16] T16B = 16'b0000000000001000;
    localparam logic [1:10] Z1 = 10'b0000110000;
    localparam logic [1:10] Z2 = 10'b0001100000;
    localparam logic [1:16] Z16A = 16'b0000000000001100;
    localparam logic [1:16] Z16B = 16'b0000000000011000;

    initial begin
        vec[0]  = '{0,0, 0,1, 0,1,6, '0,'0, '0,'0};
        vec[1]  = '{1,0, 1,0, 1,1,6, O10,O10, O16,O16};
        vec[2]  = '{1,0, 0,0, 1,1,6, O10,O10, O16,O16};
        vec[3]  = '{0,0, 0,1, 1,2,5, O10,O10, O16,O16};
        vec[4]  = '{1,0, 1,0, 2,2,5, T1,T2, T16A,T16B};
        vec[5]  = '{0,0, 0,0, 2,2,5, T1,T2, T16A,T16B};
        vec[6]  = '{0,0, 0,1, 2,3,4, T1,T2, T16A,T16B};
        vec[7]  = '{1,0, 1,0, 3,3,4, Z1,Z2, Z16A,Z16B};
        vec[8]  = '{0,0, 0,0, 3,3,4, Z1,Z2, Z16A,Z16B};
        vec[9]  = '{0,0, 0,1, 3,4,3, Z1,Z2, Z16A,Z16B};
        vec[10] = '{1,1, 0,0, 0,4,7, '0,'0, '0,'0};
        vec[11] = '{0,0, 0,1, 0,1,6, '0,'0, '0,'0};

        rst_n = 1'b0;
        clear = 1'b0;
        req   = 1'b0;
        req_r = 1'b0;
        #12;
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_valid", 32'(vld), 0);
        chk("rst_piece", 32'(pc), 0);
        chk("rst_next", 32'(nx), 0);
        chk("rst_bag", 32'(bl), 7);
        chk("rst_l1", 32'(l1), 0);
        chk("rst_l2", 32'(l2), 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req   = vec[i].req;
            clear = vec[i].clr;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(vld), 32'(vec[i].valid));
            chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'(vec[i].rdy));
            chk($sformatf("v%0d_piece", i), 32'(pc), 32'(vec[i].piece));
            chk($sformatf("v%0d_next", i), 32'(nx), 32'(vec[i].nxt));
            chk($sformatf("v%0d_bag", i), 32'(bl), 32'(vec[i].bag));
            chk($sformatf("v%0d_l1", i), 32'(l1), 32'(vec[i].l1));
            chk($sformatf("v%0d_l2", i), 32'(l2), 32'(vec[i].l2));
            chk($sformatf("v%0d_w1", i), 32'(w1), 32'(vec[i].w1));
            chk($sformatf("v%0d_w2", i), 32'(w2), 32'(vec[i].w2));
            @(negedge clk);
        end
        req   = 1'b0;
        clear = 1'b0;

        // back-to-back requests across a bag wrap
        req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int n;
            int d;
            n = 0;
            do begin
                tick();
                n++;
            end while (!vld && n < 6);
            chk($sformatf("b2b%0d_valid", k), 32'(vld), 1);
            chk($sformatf("b2b%0d_piece", k), 32'(pc), 32'((k % 7) + 1));
            if (k == 5) begin
                chk("J_l2", 32'(l2), 32'(10'b0001110000));
                chk("J_l1", 32'(l1), 32'(10'b0001000000));
            end
            if (k == 6) begin
                chk("I_l2", 32'(l2), 32'(10'b0001111000));
                chk("I_l1", 32'(l1), 0);
            end
            tick();
            chk($sformatf("b2b%0d_gap", k), 32'({rdy, vld}), 0);
            tick();
            d = ((k + 1) % 7) + 1;
            chk($sformatf("b2b%0d_rdy", k), 32'(rdy), 1);
            chk($sformatf("b2b%0d_next", k), 32'(nx), 32'(d));
            chk($sformatf("b2b%0d_bag", k), 32'(bl),
                32'((d == 7) ? 7 : 7 - d));
        end
        @(negedge clk);
        req = 1'b0;

        // async reset while in SPAWN
        @(negedge clk);
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("sp_valid", 32'(vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(vld), 0);
        chk("ar_rdy", 32'(rdy), 0);
        chk("ar_piece", 32'(pc), 0);
        chk("ar_next", 32'(nx), 0);
        chk("ar_bag", 32'(bl), 7);
        chk("ar_lines", 32'({l1, l2}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_valid", 32'(vld), 0);
        chk("rel_next", 32'(nx), 1);
        chk("rel_rdy", 32'(rdy), 1);
        tick();
        chk("rel_valid2", 32'(vld), 0);

        // random bag draws
        @(negedge clk);
        req_r = 1'b1;
        for (int s = 0; s < 70; s++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!vldr && n < 8);
            if (!vldr) chk($sformatf("rnd%0d_wait", s), 32'(vldr), 1);
            got[s] = pcr;
        end
        @(negedge clk);
        req_r = 1'b0;
        for (int g = 0; g < 10; g++) begin
            logic [7:0] seen;
            seen = 8'd0;
            for (int j = 0; j < 7; j++) seen[got[g*7+j]] = 1'b1;
            chk($sformatf("rnd_grp%0d", g), 32'(seen), 32'h000000FE);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
